// File: rtl/calc_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : calc_program_sequencer
// Purpose  : Replays a stored (op, operand) program into the stack/queue
//            calculator and reports the final tail value or the failing pc.
// Options  : CALC_SEQ_STEP_EN adds step_mode/step inputs and a PAUSE state.
// Revision : 1.0 - initial release
// ============================================================================
module calc_program_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [2:0]        prog_op,
    input  logic [DATA_W-1:0] prog_in,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_pc,
    output logic [DATA_W-1:0] result,
    output logic              result_empty,
    output logic              calc_rst,
    output logic [2:0]        calc_op,
    output logic [DATA_W-1:0] calc_in,
    output logic              calc_apply,
    input  logic [DATA_W-1:0] calc_tail,
    input  logic              calc_empty,
    input  logic              calc_valid
`ifdef CALC_SEQ_STEP_EN
    ,
    input  logic              step_mode,
    input  logic              step
`endif
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(PROG_DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        CHECK,
        FIN,
        ERR
`ifdef CALC_SEQ_STEP_EN
        ,
        PAUSE
`endif
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W:0]   len;

    logic [2:0]        op_mem [PROG_DEPTH];
    logic [DATA_W-1:0] in_mem [PROG_DEPTH];

    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W:0]   len_clamped;
    logic              last_instr;
    logic              mem_wr;

    assign pc_next     = pc + PC_ONE;
    assign len_clamped = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign last_instr  = (({1'b0, pc} + LEN_ONE) == len);
    assign mem_wr      = prog_we && (state == IDLE) && ({1'b0, prog_addr} < DEPTH_L);

    // The calculator is cleared whenever the sequencer is, and once per run.
    assign calc_rst = rst || (state == CLEAR);

    // Program storage survives reset so a host can reload only what changed.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            op_mem[prog_addr] <= prog_op;
            in_mem[prog_addr] <= prog_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pc           <= '0;
            len          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            err_pc       <= '0;
            result       <= '0;
            result_empty <= 1'b1;
            calc_op      <= '0;
            calc_in      <= '0;
            calc_apply   <= 1'b0;
        end else begin
            calc_apply <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len    <= len_clamped;
                        pc     <= '0;
                        done   <= 1'b0;
                        error  <= 1'b0;
                        err_pc <= '0;
                        busy   <= 1'b1;
                        state  <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (len != '0) begin
                        calc_apply <= 1'b1;
                        calc_op    <= op_mem[pc];
                        calc_in    <= in_mem[pc];
                        state      <= ISSUE;
                    end else begin
                        // The calculator is being cleared on this edge, so an
                        // empty program reports the post-clear (empty) state.
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        result       <= '0;
                        result_empty <= 1'b1;
                        state        <= FIN;
                    end
                end
                ISSUE: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (!calc_valid) begin
                        err_pc <= pc;
                        error  <= 1'b1;
                        busy   <= 1'b0;
                        state  <= ERR;
                    end else if (last_instr) begin
                        result       <= calc_tail;
                        result_empty <= calc_empty;
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        state        <= FIN;
                    end else begin
`ifdef CALC_SEQ_STEP_EN
                        if (step_mode) begin
                            state <= PAUSE;
                        end else begin
                            pc         <= pc_next;
                            calc_apply <= 1'b1;
                            calc_op    <= op_mem[pc_next];
                            calc_in    <= in_mem[pc_next];
                            state      <= ISSUE;
                        end
`else
                        pc         <= pc_next;
                        calc_apply <= 1'b1;
                        calc_op    <= op_mem[pc_next];
                        calc_in    <= in_mem[pc_next];
                        state      <= ISSUE;
`endif
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                ERR: begin
                    state <= IDLE;
                end
`ifdef CALC_SEQ_STEP_EN
                PAUSE: begin
                    if (step) begin
                        pc         <= pc_next;
                        calc_apply <= 1'b1;
                        calc_op    <= op_mem[pc_next];
                        calc_in    <= in_mem[pc_next];
                        state      <= ISSUE;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_program_sequencer.sv
`default_nettype none
// Bench for calc_program_sequencer: a stack-calculator stand-in drives the
// calc_* inputs, and a run-level model predicts every output cycle by cycle.
module tb_calc_program_sequencer;

    typedef logic [15:0][7:0] stk_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       prog_we = 1'b0;
    logic [3:0] prog_addr = '0;
    logic [2:0] prog_op = '0;
    logic [7:0] prog_in = '0;
    logic [4:0] prog_len = '0;
    logic       start = 1'b0;
    logic       busy, done, error, result_empty, calc_rst, calc_apply;
    logic [3:0] err_pc;
    logic [7:0] result, calc_in, calc_tail;
    logic [2:0] calc_op;
    logic       calc_empty, calc_valid;
`ifdef CALC_SEQ_STEP_EN
    logic       step_mode = 1'b0;
    logic       step = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    bit model_en = 1'b1;

    calc_program_sequencer #(.PROG_DEPTH(16), .ADDR_W(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_op(prog_op), .prog_in(prog_in), .prog_len(prog_len), .start(start),
        .busy(busy), .done(done), .error(error), .err_pc(err_pc), .result(result),
        .result_empty(result_empty), .calc_rst(calc_rst), .calc_op(calc_op),
        .calc_in(calc_in), .calc_apply(calc_apply), .calc_tail(calc_tail),
        .calc_empty(calc_empty), .calc_valid(calc_valid)
`ifdef CALC_SEQ_STEP_EN
        , .step_mode(step_mode), .step(step)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Calculator semantics: a 16-deep stack; binary ops combine the two top
    // entries (second OP top); faults on underflow, overflow, /0, %0, op 7.
    function automatic bit calc_exec(input logic [2:0] op, input logic [7:0] v,
                                     inout stk_t st, inout int sp);
        logic [7:0] a, b, r;
        if (op == 3'd0) begin
            if (sp == 16) return 1'b0;
            st[sp] = v;
            sp++;
            return 1'b1;
        end
        if (op == 3'd1) begin
            if (sp == 0) return 1'b0;
            sp--;
            return 1'b1;
        end
        if (op == 3'd7 || sp < 2) return 1'b0;
        a = st[sp-2];
        b = st[sp-1];
        if ((op == 3'd5 || op == 3'd6) && b == 8'd0) return 1'b0;
        case (op)
            3'd2:    r = a + b;
            3'd3:    r = a * b;
            3'd4:    r = a - b;
            3'd5:    r = a / b;
            default: r = a % b;
        endcase
        st[sp-2] = r;
        sp--;
        return 1'b1;
    endfunction

    // Calculator stand-in
    stk_t cst = '0;
    int   csp = 0;
    bit   cvalid = 1'b1;
    always @(posedge clk) begin : calc_mock
        stk_t t;
        int   tsp;
        bit   ok;
        if (calc_rst) begin
            csp    <= 0;
            cvalid <= 1'b1;
        end else if (calc_apply && cvalid) begin
            t   = cst;
            tsp = csp;
            ok  = calc_exec(calc_op, calc_in, t, tsp);
            cst    <= t;
            csp    <= tsp;
            cvalid <= ok;
        end
    end
    assign calc_tail  = (csp > 0) ? cst[csp-1] : 8'd0;
    assign calc_empty = (csp == 0);
    assign calc_valid = cvalid;

    // Reference model: memory image plus a per-run timeline. A run that
    // executes n instructions has CLEAR at cycle 1, instruction i issued at
    // cycle 2i+2, and its outcome visible at cycle 2n+2.
    logic [2:0] m_op [16];
    logic [7:0] m_in [16];
    logic [2:0] snap_op [16];
    logic [7:0] snap_in [16];
    int phase = 0, cyc = 0, run_end = 0;
    bit o_err, o_emp;
    int o_epc;
    logic [7:0] o_res;
    bit e_busy = 0, e_done = 0, e_error = 0, e_empty = 1, e_apply = 0;
    int e_err_pc = 0;
    logic [7:0] e_result = '0, e_in = '0;
    logic [2:0] e_op = '0;

    function automatic void eval_prog(input int len, output int n, output bit err,
                                      output int epc, output logic [7:0] res, output bit emp);
        stk_t s  = '0;
        int   sp = 0;
        err = 1'b0;
        epc = 0;
        n   = len;
        for (int i = 0; i < len; i++) begin
            if (!calc_exec(m_op[i], m_in[i], s, sp)) begin
                err = 1'b1;
                epc = i;
                n   = i + 1;
                break;
            end
        end
        res = (sp > 0) ? s[sp-1] : 8'd0;
        emp = (sp == 0);
    endfunction

    initial begin
        for (int i = 0; i < 16; i++) begin
            m_op[i] = 3'd7;
            m_in[i] = 8'd0;
        end
    end

    always @(posedge clk) begin : model
        int len, n;
        if (rst) begin
            phase = 0; e_busy = 0; e_done = 0; e_error = 0; e_err_pc = 0;
            e_result = 0; e_empty = 1; e_apply = 0; e_op = 0; e_in = 0;
        end else if (phase == 2) begin
            phase = 0;
        end else if (phase == 1) begin
            cyc++;
            e_apply = 0;
            if (cyc == run_end) begin
                e_busy = 0;
                phase  = 2;
                if (o_err) begin
                    e_error  = 1;
                    e_err_pc = o_epc;
                end else begin
                    e_done   = 1;
                    e_result = o_res;
                    e_empty  = o_emp;
                end
            end else if (cyc % 2 == 0) begin
                e_apply = 1;
                e_op    = snap_op[cyc/2-1];
                e_in    = snap_in[cyc/2-1];
            end
        end else begin
            if (prog_we) begin
                m_op[prog_addr] = prog_op;
                m_in[prog_addr] = prog_in;
            end
            if (start) begin
                len = (prog_len > 16) ? 16 : int'(prog_len);
                eval_prog(len, n, o_err, o_epc, o_res, o_emp);
                for (int i = 0; i < 16; i++) begin
                    snap_op[i] = m_op[i];
                    snap_in[i] = m_in[i];
                end
                run_end = 2 + 2 * n;
                cyc = 1; phase = 1;
                e_busy = 1; e_done = 0; e_error = 0; e_err_pc = 0;
            end
        end
    end

    always @(posedge clk) begin : compare
        #1;
        if (model_en) begin
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(e_done));
            chk("error", 32'(error), 32'(e_error));
            chk("err_pc", 32'(err_pc), 32'(e_err_pc));
            chk("result", 32'(result), 32'(e_result));
            chk("result_empty", 32'(result_empty), 32'(e_empty));
            chk("calc_apply", 32'(calc_apply), 32'(e_apply));
            chk("calc_op", 32'(calc_op), 32'(e_op));
            chk("calc_in", 32'(calc_in), 32'(e_in));
            chk("calc_rst", 32'(calc_rst), 32'(rst || (phase == 1 && cyc == 1)));
        end
    end

    task automatic load(input int a, input logic [2:0] op, input logic [7:0] v);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'(a); prog_op = op; prog_in = v;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // k counts negedges after the start edge; busy_n counts busy cycles seen.
    task automatic run(input int len, output int k, output int busy_n);
        @(negedge clk);
        prog_len = 5'(len); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1; busy_n = 0;
        while (!(done || error) && k < 200) begin
            if (busy) busy_n++;
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk("run_timeout", 32'(k), 32'd0);
    endtask

    task automatic load_add_prog();
        load(0, 3'd0, 8'd6);
        load(1, 3'd0, 8'd3);
        load(2, 3'd2, 8'd0);
    endtask

    int k, bn;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_result_empty", 32'(result_empty), 32'd1);
        chk("reset_result", 32'(result), 32'd0);

        load_add_prog();
        run(3, k, bn);
        chk("add_done_cycle", 32'(k), 32'd8);
        chk("add_busy_cycles", 32'(bn), 32'd7);
        chk("add_result", 32'(result), 32'd9);
        chk("add_not_empty", 32'(result_empty), 32'd0);
        chk("add_done", 32'(done), 32'd1);

        load(0, 3'd0, 8'd5); load(1, 3'd0, 8'd0); load(2, 3'd5, 8'd0);
        run(3, k, bn);
        chk("div0_error", 32'(error), 32'd1);
        chk("div0_err_pc", 32'(err_pc), 32'd2);
        chk("div0_done", 32'(done), 32'd0);
        chk("div0_result_kept", 32'(result), 32'd9);
        chk("div0_cycle", 32'(k), 32'd8);

        load(0, 3'd7, 8'd1);
        run(1, k, bn);
        chk("op7_err_pc", 32'({error, err_pc}), 32'h10);
        chk("op7_cycle", 32'(k), 32'd4);
        load(0, 3'd2, 8'd0);
        run(1, k, bn);
        chk("underflow_err_pc", 32'({error, err_pc}), 32'h10);

        run(0, k, bn);
        chk("len0_cycle", 32'(k), 32'd2);
        chk("len0_done_empty", 32'({done, result_empty}), 32'h3);

        for (int i = 0; i < 8; i++) load(i, 3'd0, 8'd1);
        for (int i = 8; i < 15; i++) load(i, 3'd2, 8'd0);
        load(15, 3'd0, 8'd2);
        run(20, k, bn);
        chk("clamp_cycle", 32'(k), 32'd34);
        chk("clamp_result", 32'(result), 32'd2);
        chk("clamp_done", 32'(done), 32'd1);

        // Writes and start during a run must be ignored.
        load_add_prog();
        @(negedge clk);
        prog_len = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'd0; prog_op = 3'd7; prog_in = 8'd0; start = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; start = 1'b0;
        repeat (8) @(negedge clk);
        chk("busy_write_result", 32'({done, error, result}), 32'h209);
        run(3, k, bn);
        chk("mem_unchanged_result", 32'({done, error, result}), 32'h209);

        // Reset in the middle of a run.
        @(negedge clk);
        prog_len = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 chk("midrst_calc_rst", 32'(calc_rst), 32'd1);
        @(posedge clk);
        #1 chk("midrst_outputs", 32'({busy, done, error, result_empty}), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

`ifdef CALC_SEQ_STEP_EN
        model_en = 1'b0;
        step_mode = 1'b1;
        run_step_test();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

`ifdef CALC_SEQ_STEP_EN
    task automatic run_step_test();
        int applies;
        @(negedge clk);
        prog_len = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int s = 0; s < 2; s++) begin
            applies = 0;
            repeat (10) begin
                @(negedge clk);
                if (calc_apply) applies++;
            end
            chk("step_paused", 32'({busy, done, applies[1:0]}), 32'h8 | 32'(s == 0));
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            chk("step_apply", 32'(calc_apply), 32'd1);
        end
        repeat (4) @(negedge clk);
        chk("step_result", 32'({done, busy, result}), 32'h209);
    endtask
`endif

endmodule
`default_nettype wire
